// File: rtl/gmii_tx_arbiter.sv
// N-source arbiter/mux for the shared GMII transmit port: grants one requester at a time,
// registers its bytes onto the PHY pins and enforces IFG, grant timeout and oversize marking.
module gmii_tx_arbiter #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned ARB_MODE        = 0,
  parameter int unsigned IFG_CYCLES      = 12,
  parameter int unsigned GRANT_TIMEOUT   = 64,
  parameter int unsigned MAX_FRAME_BYTES = 1530,
  localparam int unsigned GW             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  i_gmii_clk,
  input  logic                  i_sys_rst,
  input  logic [NUM_CH-1:0]     i_req,
  output logic [NUM_CH-1:0]     o_valid,
  input  logic [NUM_CH-1:0]     i_dv,
  input  logic [8*NUM_CH-1:0]   i_data,
  output logic                  o_gmii_tx_en,
  output logic                  o_gmii_tx_er,
  output logic [7:0]            o_gmii_tx_data,
  output logic                  o_tx_busy,
  output logic [GW-1:0]         o_grant_id,
  output logic                  o_frame_done,
  output logic                  o_timeout
);

  typedef enum logic [1:0] {StIdle, StWaitSof, StXmit, StGap} state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] valid_q, valid_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     ptr_q, ptr_d, ptr_nxt;
  logic [GW-1:0]     win;
  logic              win_found;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       bytes_q, bytes_d, bytes_inc;
  logic              tx_en_q, tx_en_d, tx_er_q, tx_er_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              done_q, done_d, tmo_q, tmo_d;
  logic              dv_g;
  logic [7:0]        data_g;

  assign dv_g      = i_dv[grant_q];
  assign data_g    = i_data[{grant_q, 3'b000} +: 8];
  assign bytes_inc = (bytes_q == 16'hFFFF) ? bytes_q : bytes_q + 16'd1;
  assign ptr_nxt   = (32'(grant_q) == NUM_CH - 1) ? '0 : grant_q + GW'(1);

  // Scan from the pointer (always 0 in fixed-priority mode); first hit wins.
  always_comb begin
    int unsigned idx;
    logic [GW-1:0] idx_w;
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = ((ARB_MODE != 0) ? 32'(ptr_q) : 32'd0) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_w = GW'(idx);
      if (!win_found && i_req[idx_w]) begin
        win_found = 1'b1;
        win       = idx_w;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    bytes_d   = bytes_q;
    tx_en_d   = 1'b0;
    tx_er_d   = 1'b0;
    tx_data_d = '0;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|i_req) begin
          valid_d      = '0;
          valid_d[win] = 1'b1;
          grant_d      = win;
          cnt_d        = '0;
          bytes_d      = '0;
          state_d      = StWaitSof;
        end
      end
      StWaitSof: begin
        if (dv_g) begin
          tx_en_d   = 1'b1;
          tx_data_d = data_g;
          bytes_d   = 16'd1;
          tx_er_d   = (MAX_FRAME_BYTES == 0);
          state_d   = StXmit;
        end else if (cnt_q == 16'(GRANT_TIMEOUT - 1)) begin
          valid_d = '0;
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = StGap;
          if (ARB_MODE != 0) ptr_d = ptr_nxt;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StXmit: begin
        tx_en_d   = dv_g;
        tx_data_d = data_g;
        if (dv_g) begin
          bytes_d = bytes_inc;
          tx_er_d = (32'(bytes_inc) > MAX_FRAME_BYTES);
        end else begin
          // First dv low ends the frame; any re-rise is ignored until the next grant.
          valid_d = '0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StGap;
          if (ARB_MODE != 0) ptr_d = ptr_nxt;
        end
      end
      StGap: begin
        if (cnt_q == 16'(IFG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_gmii_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q   <= StIdle;
      valid_q   <= '0;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      bytes_q   <= '0;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      bytes_q   <= bytes_d;
      tx_en_q   <= tx_en_d;
      tx_er_q   <= tx_er_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
    end
  end

  assign o_valid        = valid_q;
  assign o_grant_id     = grant_q;
  assign o_gmii_tx_en   = tx_en_q;
  assign o_gmii_tx_er   = tx_er_q;
  assign o_gmii_tx_data = tx_data_q;
  assign o_frame_done   = done_q;
  assign o_timeout      = tmo_q;
  assign o_tx_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Bench for gmii_tx_arbiter: a fixed-priority and a round-robin instance, each checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_gmii_tx_arbiter;
  localparam int NCH = 4, IFG = 12, GT = 64, MAXB = 100;

  logic clk = 1'b0, rst = 1'b1;
  logic [3:0]  req [2], dv [2], valid [2];
  logic [31:0] data [2];
  logic        tx_en [2], tx_er [2], busy [2], done [2], tmo [2];
  logic [7:0]  txd [2];
  logic [1:0]  gid [2];
  int checks = 0, errors = 0;
  int done_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  gmii_tx_arbiter #(.NUM_CH(NCH), .ARB_MODE(0), .IFG_CYCLES(IFG), .GRANT_TIMEOUT(GT),
    .MAX_FRAME_BYTES(MAXB)) u_fp (
    .i_gmii_clk(clk), .i_sys_rst(rst), .i_req(req[0]), .o_valid(valid[0]), .i_dv(dv[0]),
    .i_data(data[0]), .o_gmii_tx_en(tx_en[0]), .o_gmii_tx_er(tx_er[0]),
    .o_gmii_tx_data(txd[0]), .o_tx_busy(busy[0]), .o_grant_id(gid[0]),
    .o_frame_done(done[0]), .o_timeout(tmo[0]));

  gmii_tx_arbiter #(.NUM_CH(NCH), .ARB_MODE(1), .IFG_CYCLES(IFG), .GRANT_TIMEOUT(GT),
    .MAX_FRAME_BYTES(MAXB)) u_rr (
    .i_gmii_clk(clk), .i_sys_rst(rst), .i_req(req[1]), .o_valid(valid[1]), .i_dv(dv[1]),
    .i_data(data[1]), .o_gmii_tx_en(tx_en[1]), .o_gmii_tx_er(tx_er[1]),
    .o_gmii_tx_data(txd[1]), .o_tx_busy(busy[1]), .o_grant_id(gid[1]),
    .o_frame_done(done[1]), .o_timeout(tmo[1]));

  // Model: owner channel (-1 = none), remaining gap cycles, wait age, bytes sent, RR pointer.
  int m_g [2] = '{-1, -1};
  int m_gap [2] = '{0, 0};
  int m_age [2] = '{0, 0};
  int m_bytes [2] = '{0, 0};
  int m_ptr [2] = '{0, 0};
  bit m_infr [2] = '{0, 0};
  logic [3:0] e_valid [2] = '{4'h0, 4'h0};
  int   e_id [2] = '{0, 0};
  logic [7:0] e_data [2] = '{8'h0, 8'h0};
  bit e_en [2] = '{0, 0}, e_er [2] = '{0, 0}, e_busy [2] = '{0, 0};
  bit e_done [2] = '{0, 0}, e_tmo [2] = '{0, 0};

  function automatic int pick(input int d, input logic [3:0] r);
    for (int k = 0; k < NCH; k++) begin
      int i;
      i = (d == 0) ? k : (m_ptr[d] + k) % NCH;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_release(input int d, input int g);
    e_valid[d] = 4'h0;
    m_gap[d]   = IFG;
    if (d == 1) m_ptr[d] = (g + 1) % NCH;
    m_g[d]     = -1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_g[d] = -1; m_gap[d] = 0; m_age[d] = 0; m_bytes[d] = 0; m_ptr[d] = 0; m_infr[d] = 0;
      e_valid[d] = 4'h0; e_id[d] = 0; e_data[d] = 8'h0; e_en[d] = 0; e_er[d] = 0;
      e_busy[d] = 0; e_done[d] = 0; e_tmo[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    logic [3:0] r, v;
    logic [31:0] dat;
    int g;
    r = req[d]; v = dv[d]; dat = data[d]; g = m_g[d];
    e_en[d] = 0; e_er[d] = 0; e_done[d] = 0; e_tmo[d] = 0;
    if (g < 0) begin
      if (m_gap[d] > 0) m_gap[d]--;
      else if (r != 4'h0) begin
        g = pick(d, r);
        m_g[d] = g; e_valid[d] = 4'b0001 << g; e_id[d] = g; m_age[d] = 0; m_infr[d] = 0;
      end
    end else if (v[g]) begin
      m_bytes[d] = m_infr[d] ? m_bytes[d] + 1 : 1;
      m_infr[d]  = 1;
      e_en[d] = 1; e_data[d] = dat[8*g +: 8]; e_er[d] = (m_bytes[d] > MAXB);
    end else if (m_infr[d]) begin
      e_done[d] = 1; model_release(d, g);
    end else if (m_age[d] + 1 == GT) begin
      e_tmo[d] = 1; model_release(d, g);
    end else begin
      m_age[d]++;
    end
    e_busy[d] = (m_g[d] >= 0) || (m_gap[d] > 0);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic check(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", nm, d, $time, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired t=%0t", nm, $time);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check("valid", d, 32'(valid[d]), 32'(e_valid[d]));
      check("grant_id", d, 32'(gid[d]), 32'(e_id[d]));
      check("tx_en", d, 32'(tx_en[d]), 32'(e_en[d]));
      check("tx_er", d, 32'(tx_er[d]), 32'(e_er[d]));
      check("busy", d, 32'(busy[d]), 32'(e_busy[d]));
      check("frame_done", d, 32'(done[d]), 32'(e_done[d]));
      check("timeout", d, 32'(tmo[d]), 32'(e_tmo[d]));
      if (e_en[d]) check("tx_data", d, 32'(txd[d]), 32'(e_data[d]));
      done_cnt[d] += int'(done[d]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random sources: 0 idle/noise, 1 requesting, 2 pre-SOF delay, 3 sending, 4 dv glitch.
  int a_st [2][4], a_dly [2][4], a_len [2][4];

  task automatic agents_step(input int d);
    for (int c = 0; c < NCH; c++) begin
      case (a_st[d][c])
        0: begin
          req[d][c] = 1'b0;
          dv[d][c]  = ($urandom_range(3) == 0);
          data[d][8*c +: 8] = 8'($urandom);
          if ($urandom_range(11) == 0) begin
            a_st[d][c] = 1; req[d][c] = 1'b1; dv[d][c] = 1'b0;
          end
        end
        1: begin
          if (valid[d][c]) begin
            req[d][c]   = 1'b0;
            a_dly[d][c] = ($urandom_range(15) == 0) ? GT + 5 : int'($urandom_range(3));
            a_len[d][c] = ($urandom_range(15) == 0) ? int'($urandom_range(110, 100))
                                                     : int'($urandom_range(24, 1));
            a_st[d][c]  = 2;
          end else if ($urandom_range(63) == 0) begin
            req[d][c] = 1'b0; a_st[d][c] = 0;
          end
        end
        2: begin
          if (!valid[d][c]) a_st[d][c] = 0;
          else if (a_dly[d][c] == 0) a_st[d][c] = 3;
          else a_dly[d][c]--;
        end
        3: begin
          if (a_len[d][c] == 0) begin
            dv[d][c] = 1'b0;
            a_st[d][c] = ($urandom_range(3) == 0) ? 4 : 0;
          end else begin
            dv[d][c] = 1'b1; data[d][8*c +: 8] = 8'($urandom); a_len[d][c]--;
          end
        end
        default: begin
          dv[d][c] = 1'b1; data[d][8*c +: 8] = 8'($urandom); a_st[d][c] = 0;
        end
      endcase
    end
  endtask

  initial begin
    int n, k, g, erc, first, dc0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 4'h0; dv[d] = 4'h0; data[d] = 32'h0;
      for (int c = 0; c < NCH; c++) begin a_st[d][c] = 0; a_dly[d][c] = 0; a_len[d][c] = 0; end
    end
    repeat (3) tick();
    check("rst_valid", 0, 32'(valid[0]), 32'h0);
    check("rst_tx_en", 0, 32'(tx_en[0]), 32'h0);
    check("rst_busy", 1, 32'(busy[1]), 32'h0);
    rst = 1'b0;

    // Round-robin: all four keep requesting, 10-byte frames.
    req[1] = 4'hF;
    for (int f = 0; f < 5; f++) begin
      n = 0;
      while (valid[1] == 4'h0 && n < 100) begin tick(); n++; end
      if (n >= 100) expire("rr_grant");
      g = int'(gid[1]);
      check("rr_order", 1, 32'(g), 32'(f % NCH));
      req[1][g] = 1'b0;
      for (int i = 0; i < 10; i++) begin
        dv[1][g] = 1'b1; data[1][8*g +: 8] = 8'($urandom); tick();
      end
      dv[1][g] = 1'b0; req[1][g] = 1'b1;
      tick();
    end
    req[1] = 4'h0;
    repeat (20) tick();

    // Fixed priority: ch1 beats ch3; ch3 toggles noise during ch1's frame.
    dc0 = done_cnt[0];
    req[0] = 4'b1010;
    tick();
    check("fp_grant", 0, 32'(valid[0]), 32'b0010);
    check("fp_grant_id", 0, 32'(gid[0]), 32'd1);
    req[0][1] = 1'b0;
    for (int i = 0; i < 64; i++) begin
      dv[0][1] = 1'b1; data[0][15:8] = 8'(i);
      dv[0][3] = 1'($urandom); data[0][31:24] = 8'($urandom);
      tick();
      if (i == 0 || i == 63) begin
        check("fp_byte", 0, 32'(txd[0]), 32'(i));
        check("fp_en", 0, 32'(tx_en[0]), 32'd1);
      end
    end
    dv[0][1] = 1'b0; dv[0][3] = 1'b0;
    tick();
    check("fp_done", 0, 32'(done[0]), 32'd1);
    n = 0;
    while (valid[0] != 4'b1000 && n < 50) begin tick(); n++; end
    check("fp_ifg_grant", 0, 32'(n), 32'(IFG + 1));
    check("fp_done_count", 0, 32'(done_cnt[0] - dc0), 32'd1);

    // Timeout: ch3 never raises dv.
    req[0][3] = 1'b0;
    k = 0;
    while (valid[0][3] && k < 200) begin k++; tick(); end
    check("to_len", 0, 32'(k), 32'(GT));
    check("to_pulse", 0, 32'(tmo[0]), 32'd1);
    req[0][0] = 1'b1;
    n = 0;
    while (valid[0] != 4'b0001 && n < 50) begin tick(); n++; end
    check("to_next_grant", 0, 32'(n), 32'(IFG + 1));

    // Oversize: 105 bytes with a 100-byte limit.
    req[0][0] = 1'b0; erc = 0; first = 0;
    for (int i = 1; i <= 105; i++) begin
      dv[0][0] = 1'b1; data[0][7:0] = 8'(i);
      tick();
      if (tx_er[0]) begin erc++; if (first == 0) first = i; end
    end
    dv[0][0] = 1'b0;
    tick();
    check("ovs_er_count", 0, 32'(erc), 32'd5);
    check("ovs_first_er", 0, 32'(first), 32'(MAXB + 1));

    // Reset mid-frame; RR pointer (left at 1 above) must come back as 0.
    repeat (IFG + 2) tick();
    req[0][0] = 1'b1;
    n = 0;
    while (valid[0] != 4'b0001 && n < 50) begin tick(); n++; end
    if (n >= 50) expire("rst_pre_grant");
    for (int i = 1; i <= 30; i++) begin
      dv[0][0] = 1'b1; data[0][7:0] = 8'(i); tick();
    end
    rst = 1'b1; req[1] = 4'hF;
    #1;
    check("rst_mid_en", 0, 32'(tx_en[0]), 32'h0);
    check("rst_mid_data", 0, 32'(txd[0]), 32'h0);
    check("rst_mid_valid", 0, 32'(valid[0]), 32'h0);
    check("rst_mid_busy", 0, 32'(busy[0]), 32'h0);
    dv[0] = 4'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_regrant_fp", 0, 32'(valid[0]), 32'b0001);
    check("rst_regrant_rr", 1, 32'(valid[1]), 32'b0001);
    req[0] = 4'h0; req[1] = 4'h0;

    repeat (4000) begin
      tick();
      agents_step(0);
      agents_step(1);
    end
    for (int d = 0; d < 2; d++) begin req[d] = 4'h0; dv[d] = 4'h0; end
    repeat (150) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
